// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared types and constants for the two-core MSI snooping bus arbiter.
package coherence_bus_arbiter_pkg;

   localparam int DEF_ADDR_W      = 13;
   localparam int DEF_DATA_W      = 16;
   localparam int DEF_MEM_TIMEOUT = 64;

   localparam logic [1:0] SOURCE_DMEM       = 2'b00;
   localparam logic [1:0] SOURCE_OTHER_PROC = 2'b01;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SNOOP = 3'd1,
      MEM   = 3'd2,
      RESP  = 3'd3,
      INVAL = 3'd4
   } arb_state_t;

   typedef enum logic [1:0] {
      REQ_READ  = 2'd0,
      REQ_WRITE = 2'd1,
      REQ_INV   = 2'd2
   } bus_req_t;

   // Same-cycle pulses from one core resolve write > read > invalidate.
   function automatic bus_req_t req_decode(input logic rd, input logic wr, input logic inv);
      bus_req_t t;
      if (wr) begin
         t = REQ_WRITE;
      end else if (rd) begin
         t = REQ_READ;
      end else begin
         t = inv ? REQ_INV : REQ_READ;
      end
      return t;
   endfunction

endpackage

// File: rtl/coherence_bus_arbiter_if.sv
// Core-facing request/snoop/response bundle between the cache controllers and the arbiter.
interface coherence_bus_arbiter_if
   import coherence_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic [1:0]        read_miss;
   logic [1:0]        write_miss;
   logic [1:0]        invalidate;
   logic [ADDR_W-1:0] BICO0;
   logic [ADDR_W-1:0] BICO1;
   logic [1:0]        cpu_search_found;
   logic [DATA_W-1:0] send_other_proc_data0;
   logic [DATA_W-1:0] send_other_proc_data1;
   logic              u_rdy;
   logic [1:0]        grant;
   logic [1:0]        cpu_datasel0;
   logic [1:0]        cpu_datasel1;
   logic [ADDR_W-1:0] BOCI0;
   logic [ADDR_W-1:0] BOCI1;
   logic [1:0]        cpu_search;
   logic [DATA_W-1:0] other_proc_data;
   logic [1:0]        invalidate_from_other_cpu;
   logic [1:0]        cpu_dmem_permission;
   logic              mem_timeout_err;

   modport master (
      output read_miss, write_miss, invalidate, BICO0, BICO1, cpu_search_found,
             send_other_proc_data0, send_other_proc_data1, u_rdy,
      input  grant, cpu_datasel0, cpu_datasel1, BOCI0, BOCI1, cpu_search,
             other_proc_data, invalidate_from_other_cpu, cpu_dmem_permission, mem_timeout_err
   );

   modport slave (
      input  read_miss, write_miss, invalidate, BICO0, BICO1, cpu_search_found,
             send_other_proc_data0, send_other_proc_data1, u_rdy,
      output grant, cpu_datasel0, cpu_datasel1, BOCI0, BOCI1, cpu_search,
             other_proc_data, invalidate_from_other_cpu, cpu_dmem_permission, mem_timeout_err
   );

endinterface

// File: rtl/coherence_bus_arbiter_bus_req_latch.sv
// Per-core pending request holder; a new pulse wins over the grant-cycle clear.
module coherence_bus_arbiter_bus_req_latch
   import coherence_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read_miss_i,
   input  logic              write_miss_i,
   input  logic              invalidate_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              clear_i,
   output logic              pending_o,
   output bus_req_t          type_o,
   output logic [ADDR_W-1:0] addr_o
);

   logic              pending_q, pending_d;
   bus_req_t          type_q, type_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              req_any_s;

   // Capture/overwrite on any pulse, otherwise drop on grant.
   always_comb begin
      req_any_s = read_miss_i | write_miss_i | invalidate_i;
      pending_d = pending_q;
      type_d    = type_q;
      addr_d    = addr_q;
      if (req_any_s) begin
         pending_d = 1'b1;
         type_d    = req_decode(read_miss_i, write_miss_i, invalidate_i);
         addr_d    = addr_i;
      end else if (clear_i) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
   end

   // Request state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= 1'b0;
         type_q    <= REQ_READ;
         addr_q    <= {ADDR_W{1'b0}};
      end else begin
         pending_q <= pending_d;
         type_q    <= type_d;
         addr_q    <= addr_d;
      end
   end

   assign pending_o = pending_q;
   assign type_o    = type_q;
   assign addr_o    = addr_q;

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Serializes both cores' misses/upgrades, snoops the peer cache and sources fills
// from the peer or DMEM; all core-facing outputs are registered.
module coherence_bus_arbiter
   import coherence_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   coherence_bus_arbiter_if.slave bus_if
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   logic [1:0]        pend_s;
   bus_req_t          ptype_s [2];
   logic [ADDR_W-1:0] paddr_s [2];

   arb_state_t        state_q, state_d;
   logic              owner_q, owner_d, last_q, last_d, found_q, found_d, err_q, err_d;
   bus_req_t          type_q, type_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              peer_s;

   logic [1:0]        grant_q, grant_d, search_q, search_d, perm_q, perm_d, inv_q, inv_d;
   logic [1:0]        sel0_q, sel0_d, sel1_q, sel1_d;
   logic [ADDR_W-1:0] boci0_q, boci0_d, boci1_q, boci1_d;
   logic [DATA_W-1:0] opd_q, opd_d;

   coherence_bus_arbiter_bus_req_latch #(.ADDR_W(ADDR_W)) u_req0 (
      .clk(clk), .rst_n(rst_n),
      .read_miss_i(bus_if.read_miss[0]), .write_miss_i(bus_if.write_miss[0]),
      .invalidate_i(bus_if.invalidate[0]), .addr_i(bus_if.BICO0), .clear_i(grant_q[0]),
      .pending_o(pend_s[0]), .type_o(ptype_s[0]), .addr_o(paddr_s[0])
   );

   coherence_bus_arbiter_bus_req_latch #(.ADDR_W(ADDR_W)) u_req1 (
      .clk(clk), .rst_n(rst_n),
      .read_miss_i(bus_if.read_miss[1]), .write_miss_i(bus_if.write_miss[1]),
      .invalidate_i(bus_if.invalidate[1]), .addr_i(bus_if.BICO1), .clear_i(grant_q[1]),
      .pending_o(pend_s[1]), .type_o(ptype_s[1]), .addr_o(paddr_s[1])
   );

   // FSM state and transaction context registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         found_q <= 1'b0;
         err_q   <= 1'b0;
         type_q  <= REQ_READ;
         addr_q  <= {ADDR_W{1'b0}};
         wait_q  <= {WAIT_W{1'b0}};
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         found_q <= found_d;
         err_q   <= err_d;
         type_q  <= type_d;
         addr_q  <= addr_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state logic; on a tie the core not served last wins.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      found_d = found_q;
      err_d   = err_q;
      type_d  = type_q;
      addr_d  = addr_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: begin
            if (pend_s != 2'b00) begin
               owner_d = (pend_s == 2'b11) ? ~last_q : pend_s[1];
               type_d  = ptype_s[owner_d];
               addr_d  = paddr_s[owner_d];
               found_d = 1'b0;
               state_d = (type_d == REQ_INV) ? INVAL : SNOOP;
            end else begin
               state_d = IDLE;
            end
         end
         SNOOP: begin
            found_d = bus_if.cpu_search_found[~owner_q];
            wait_d  = {WAIT_W{1'b0}};
            state_d = found_d ? RESP : MEM;
         end
         MEM: begin
            if (bus_if.u_rdy) begin
               state_d = RESP;
            end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               wait_d  = wait_q + WAIT_W'(1);
            end
         end
         RESP, INVAL: begin
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so every output is a flop.
   always_comb begin
      peer_s   = ~owner_d;
      grant_d  = 2'b00;
      search_d = 2'b00;
      perm_d   = 2'b00;
      inv_d    = 2'b00;
      boci0_d  = {ADDR_W{1'b0}};
      boci1_d  = {ADDR_W{1'b0}};
      sel0_d   = sel0_q;
      sel1_d   = sel1_q;
      opd_d    = opd_q;
      case (state_d)
         SNOOP: search_d[peer_s] = 1'b1;
         MEM:   perm_d[owner_d]  = 1'b1;
         RESP: begin
            grant_d[owner_d] = 1'b1;
            if (type_d == REQ_WRITE && found_d) begin
               inv_d[peer_s] = 1'b1;
            end else begin
               inv_d = 2'b00;
            end
         end
         INVAL: begin
            grant_d[owner_d] = 1'b1;
            inv_d[peer_s]    = 1'b1;
         end
         default: begin
            grant_d = 2'b00;
         end
      endcase
      if (state_d == SNOOP || state_d == RESP || state_d == INVAL) begin
         if (peer_s) begin
            boci1_d = addr_d;
         end else begin
            boci0_d = addr_d;
         end
      end else begin
         boci0_d = {ADDR_W{1'b0}};
      end
      // Only the owner's fill-source select changes; the peer's holds.
      if (state_q == SNOOP && found_d) begin
         opd_d = owner_q ? bus_if.send_other_proc_data0 : bus_if.send_other_proc_data1;
         if (owner_q) begin
            sel1_d = SOURCE_OTHER_PROC;
         end else begin
            sel0_d = SOURCE_OTHER_PROC;
         end
      end else if (state_q == MEM && state_d == RESP) begin
         if (owner_q) begin
            sel1_d = SOURCE_DMEM;
         end else begin
            sel0_d = SOURCE_DMEM;
         end
      end else begin
         opd_d = opd_q;
      end
   end

   // Registered core-facing outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q  <= 2'b00;
         search_q <= 2'b00;
         perm_q   <= 2'b00;
         inv_q    <= 2'b00;
         sel0_q   <= SOURCE_DMEM;
         sel1_q   <= SOURCE_DMEM;
         boci0_q  <= {ADDR_W{1'b0}};
         boci1_q  <= {ADDR_W{1'b0}};
         opd_q    <= {DATA_W{1'b0}};
      end else begin
         grant_q  <= grant_d;
         search_q <= search_d;
         perm_q   <= perm_d;
         inv_q    <= inv_d;
         sel0_q   <= sel0_d;
         sel1_q   <= sel1_d;
         boci0_q  <= boci0_d;
         boci1_q  <= boci1_d;
         opd_q    <= opd_d;
      end
   end

   assign bus_if.grant                     = grant_q;
   assign bus_if.cpu_search                = search_q;
   assign bus_if.cpu_dmem_permission       = perm_q;
   assign bus_if.invalidate_from_other_cpu = inv_q;
   assign bus_if.cpu_datasel0              = sel0_q;
   assign bus_if.cpu_datasel1              = sel1_q;
   assign bus_if.BOCI0                     = boci0_q;
   assign bus_if.BOCI1                     = boci1_q;
   assign bus_if.other_proc_data           = opd_q;
   assign bus_if.mem_timeout_err           = err_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for coherence_bus_arbiter.
module tb_coherence_bus_arbiter;

   typedef struct packed {
      logic [1:0]  grant;
      logic [1:0]  search;
      logic [1:0]  perm;
      logic [1:0]  inv;
      logic [12:0] boci0;
      logic [12:0] boci1;
      logic [1:0]  sel0;
      logic [1:0]  sel1;
      logic [15:0] opd;
      logic        err;
   } obs_t;

   typedef struct {
      logic [1:0]  rm, wm, iv;
      logic [12:0] b0, b1;
      logic [1:0]  fnd;
      logic [15:0] d1;
      logic        rdy;
      obs_t        exp;
   } vec_t;

   localparam int NVEC = 21;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   vec_t tbl [NVEC];

   coherence_bus_arbiter_if bif ();

   coherence_bus_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus_if(bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t mko(input logic [1:0] g, s, p, i, input logic [12:0] b0, b1,
                                input logic [1:0] s0, s1, input logic [15:0] d, input logic e);
      obs_t o;
      o = '{grant:g, search:s, perm:p, inv:i, boci0:b0, boci1:b1, sel0:s0, sel1:s1, opd:d, err:e};
      return o;
   endfunction

   function automatic vec_t mkv(input logic [1:0] rm, wm, iv, input logic [12:0] b0, b1,
                                input logic [1:0] fnd, input logic [15:0] d1, input logic rdy,
                                input obs_t e);
      vec_t v;
      v.rm = rm; v.wm = wm; v.iv = iv; v.b0 = b0; v.b1 = b1;
      v.fnd = fnd; v.d1 = d1; v.rdy = rdy; v.exp = e;
      return v;
   endfunction

   function automatic obs_t get_obs();
      obs_t o;
      o = '{grant:bif.grant, search:bif.cpu_search, perm:bif.cpu_dmem_permission,
            inv:bif.invalidate_from_other_cpu, boci0:bif.BOCI0, boci1:bif.BOCI1,
            sel0:bif.cpu_datasel0, sel1:bif.cpu_datasel1, opd:bif.other_proc_data,
            err:bif.mem_timeout_err};
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] rm, wm, iv, input logic [12:0] b0, b1,
                        input logic [1:0] fnd, input logic [15:0] d0, d1, input logic rdy);
      bif.read_miss = rm; bif.write_miss = wm; bif.invalidate = iv;
      bif.BICO0 = b0; bif.BICO1 = b1; bif.cpu_search_found = fnd;
      bif.send_other_proc_data0 = d0; bif.send_other_proc_data1 = d1; bif.u_rdy = rdy;
   endtask

   task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_grant(input string name, input int budget, output int n);
      n = 0;
      while (n < budget) begin
         tick();
         n++;
         if (bif.grant !== 2'b00) break;
      end
      if (bif.grant === 2'b00) begin
         checks++;
         failures++;
         $display("FAIL %s actual=no_grant required=grant_within_%0d", name, budget);
         n = -1;
      end
   endtask

   initial begin
      int   n;
      logic bad;
      checks   = 0;
      failures = 0;

      // Peer read hit, core 0
      tbl[0]  = mkv(2'b01, 2'b00, 2'b00, 13'h0104, 13'h0000, 2'b10, 16'hBEEF, 1'b0,
                    mko(2'b00, 2'b00, 2'b00, 2'b00, 13'h0, 13'h0,    2'b00, 2'b00, 16'h0000, 1'b0));
      tbl[1]  = mkv(2'b00, 2'b00, 2'b00, 13'h0104, 13'h0000, 2'b10, 16'hBEEF, 1'b0,
                    mko(2'b00, 2'b10, 2'b00, 2'b00, 13'h0, 13'h0104, 2'b00, 2'b00, 16'h0000, 1'b0));
      tbl[2]  = mkv(2'b00, 2'b00, 2'b00, 13'h0104, 13'h0000, 2'b10, 16'hBEEF, 1'b0,
                    mko(2'b01, 2'b00, 2'b00, 2'b00, 13'h0, 13'h0104, 2'b01, 2'b00, 16'hBEEF, 1'b0));
      tbl[3]  = mkv(2'b00, 2'b00, 2'b00, 13'h0104, 13'h0000, 2'b10, 16'hBEEF, 1'b0,
                    mko(2'b00, 2'b00, 2'b00, 2'b00, 13'h0, 13'h0,    2'b01, 2'b00, 16'hBEEF, 1'b0));
      // Upgrade invalidate, core 0, top address
      tbl[4]  = mkv(2'b00, 2'b00, 2'b01, 13'h1FFF, 13'h0000, 2'b00, 16'h0000, 1'b0,
                    mko(2'b00, 2'b00, 2'b00, 2'b00, 13'h0, 13'h0,    2'b01, 2'b00, 16'hBEEF, 1'b0));
      tbl[5]  = mkv(2'b00, 2'b00, 2'b00, 13'h1FFF, 13'h0000, 2'b00, 16'h0000, 1'b0,
                    mko(2'b01, 2'b00, 2'b00, 2'b10, 13'h0, 13'h1FFF, 2'b01, 2'b00, 16'hBEEF, 1'b0));
      tbl[6]  = mkv(2'b00, 2'b00, 2'b00, 13'h1FFF, 13'h0000, 2'b00, 16'h0000, 1'b0,
                    mko(2'b00, 2'b00, 2'b00, 2'b00, 13'h0, 13'h0,    2'b01, 2'b00, 16'hBEEF, 1'b0));
      // Write miss, core 0, peer hit -> peer invalidated alongside grant
      tbl[7]  = mkv(2'b00, 2'b01, 2'b00, 13'h0AAA, 13'h0000, 2'b10, 16'h1234, 1'b0,
                    mko(2'b00, 2'b00, 2'b00, 2'b00, 13'h0, 13'h0,    2'b01, 2'b00, 16'hBEEF, 1'b0));
      tbl[8]  = mkv(2'b00, 2'b00, 2'b00, 13'h0AAA, 13'h0000, 2'b10, 16'h1234, 1'b0,
                    mko(2'b00, 2'b10, 2'b00, 2'b00, 13'h0, 13'h0AAA, 2'b01, 2'b00, 16'hBEEF, 1'b0));
      tbl[9]  = mkv(2'b00, 2'b00, 2'b00, 13'h0AAA, 13'h0000, 2'b10, 16'h1234, 1'b0,
                    mko(2'b01, 2'b00, 2'b00, 2'b10, 13'h0, 13'h0AAA, 2'b01, 2'b00, 16'h1234, 1'b0));
      tbl[10] = mkv(2'b00, 2'b00, 2'b00, 13'h0AAA, 13'h0000, 2'b10, 16'h1234, 1'b0,
                    mko(2'b00, 2'b00, 2'b00, 2'b00, 13'h0, 13'h0,    2'b01, 2'b00, 16'h1234, 1'b0));
      // Write miss, core 1, peer miss, DMEM ready after 5 low cycles
      tbl[11] = mkv(2'b00, 2'b10, 2'b00, 13'h0000, 13'h0020, 2'b00, 16'h0000, 1'b0,
                    mko(2'b00, 2'b00, 2'b00, 2'b00, 13'h0,    13'h0, 2'b01, 2'b00, 16'h1234, 1'b0));
      tbl[12] = mkv(2'b00, 2'b00, 2'b00, 13'h0000, 13'h0020, 2'b00, 16'h0000, 1'b0,
                    mko(2'b00, 2'b01, 2'b00, 2'b00, 13'h0020, 13'h0, 2'b01, 2'b00, 16'h1234, 1'b0));
      for (int i = 13; i < 19; i++) begin
         tbl[i] = mkv(2'b00, 2'b00, 2'b00, 13'h0000, 13'h0020, 2'b00, 16'h0000, 1'b0,
                      mko(2'b00, 2'b00, 2'b10, 2'b00, 13'h0, 13'h0, 2'b01, 2'b00, 16'h1234, 1'b0));
      end
      tbl[19] = mkv(2'b00, 2'b00, 2'b00, 13'h0000, 13'h0020, 2'b00, 16'h0000, 1'b1,
                    mko(2'b10, 2'b00, 2'b00, 2'b00, 13'h0020, 13'h0, 2'b01, 2'b00, 16'h1234, 1'b0));
      tbl[20] = mkv(2'b00, 2'b00, 2'b00, 13'h0000, 13'h0020, 2'b00, 16'h0000, 1'b0,
                    mko(2'b00, 2'b00, 2'b00, 2'b00, 13'h0,    13'h0, 2'b01, 2'b00, 16'h1234, 1'b0));

      drive(2'b00, 2'b00, 2'b00, 13'h0, 13'h0, 2'b00, 16'h0, 16'h0, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_obs("reset_state", get_obs(), '0);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i].rm, tbl[i].wm, tbl[i].iv, tbl[i].b0, tbl[i].b1, tbl[i].fnd,
               16'h0000, tbl[i].d1, tbl[i].rdy);
         tick();
         chk_obs($sformatf("vec%0d", i), get_obs(), tbl[i].exp);
      end

      // Collision with core 1 served last: core 0 first, then core 1
      drive(2'b11, 2'b00, 2'b00, 13'h0011, 13'h0022, 2'b11, 16'hAAAA, 16'h5555, 1'b0);
      tick();
      drive(2'b00, 2'b00, 2'b00, 13'h0011, 13'h0022, 2'b11, 16'hAAAA, 16'h5555, 1'b0);
      wait_grant("coll1_first", 10, n);
      chk("coll1_first_lat", n, 2);
      chk("coll1_first_grant", bif.grant, 2'b01);
      chk("coll1_first_data", bif.other_proc_data, 16'h5555);
      wait_grant("coll1_second", 10, n);
      chk("coll1_second_lat", n, 3);
      chk("coll1_second_grant", bif.grant, 2'b10);
      chk("coll1_second_data", bif.other_proc_data, 16'hAAAA);
      chk("coll1_second_sel1", bif.cpu_datasel1, 2'b01);

      // Re-pulse during own grant cycle: request must survive the clear
      drive(2'b00, 2'b00, 2'b01, 13'h0003, 13'h0000, 2'b00, 16'h0, 16'h0, 1'b0);
      tick();
      drive(2'b00, 2'b00, 2'b00, 13'h0003, 13'h0000, 2'b00, 16'h0, 16'h0, 1'b0);
      wait_grant("inv_first", 5, n);
      chk("inv_first_lat", n, 1);
      drive(2'b00, 2'b00, 2'b01, 13'h0003, 13'h0000, 2'b00, 16'h0, 16'h0, 1'b0);
      tick();
      drive(2'b00, 2'b00, 2'b00, 13'h0003, 13'h0000, 2'b00, 16'h0, 16'h0, 1'b0);
      wait_grant("set_wins", 5, n);
      chk("set_wins_lat", n, 1);
      chk("set_wins_grant", bif.grant, 2'b01);

      // Collision with core 0 served last: core 1 first
      drive(2'b11, 2'b00, 2'b00, 13'h0011, 13'h0022, 2'b11, 16'hAAAA, 16'h5555, 1'b0);
      tick();
      drive(2'b00, 2'b00, 2'b00, 13'h0011, 13'h0022, 2'b11, 16'hAAAA, 16'h5555, 1'b0);
      wait_grant("coll2_first", 10, n);
      chk("coll2_first_lat", n, 2);
      chk("coll2_first_grant", bif.grant, 2'b10);
      wait_grant("coll2_second", 10, n);
      chk("coll2_second_grant", bif.grant, 2'b01);

      // DMEM never ready: timeout after 64 MEM cycles, grant still issued
      drive(2'b10, 2'b00, 2'b00, 13'h0000, 13'h0055, 2'b00, 16'h0, 16'h0, 1'b0);
      tick();
      drive(2'b00, 2'b00, 2'b00, 13'h0000, 13'h0055, 2'b00, 16'h0, 16'h0, 1'b0);
      tick();
      tick();
      chk("tmo_perm", bif.cpu_dmem_permission, 2'b10);
      chk("tmo_err_before", bif.mem_timeout_err, 1'b0);
      wait_grant("tmo_grant", 100, n);
      chk("tmo_lat", n, 64);
      chk("tmo_grant_val", bif.grant, 2'b10);
      chk("tmo_err_set", bif.mem_timeout_err, 1'b1);
      tick();
      chk("tmo_err_sticky", bif.mem_timeout_err, 1'b1);

      // Asynchronous reset mid-MEM with core 1 also pending
      drive(2'b01, 2'b00, 2'b00, 13'h0077, 13'h0066, 2'b00, 16'h0, 16'h0, 1'b0);
      tick();
      drive(2'b10, 2'b00, 2'b00, 13'h0077, 13'h0066, 2'b00, 16'h0, 16'h0, 1'b0);
      tick();
      drive(2'b00, 2'b00, 2'b00, 13'h0077, 13'h0066, 2'b00, 16'h0, 16'h0, 1'b0);
      tick();
      chk("rst_mid_perm", bif.cpu_dmem_permission, 2'b01);
      #2;
      rst_n = 1'b0;
      #1;
      chk_obs("rst_mid_outputs", get_obs(), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bif.grant !== 2'b00 || bif.cpu_search !== 2'b00 || bif.cpu_dmem_permission !== 2'b00)
            bad = 1'b1;
      end
      chk("rst_pending_cleared", bad, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/coherence_bus_arbiter.md
Name: coherence_bus_arbiter

Overview:
Snooping bus controller for the two-core MSI system. It sits directly downstream of both per-core cache_controller instances and consumes their read_miss/write_miss/invalidate pulses and BICO addresses. It serializes those requests and snoops the peer cache. It then sources fill data either from the peer cache (cache-to-cache) or from unified DMEM, and returns grant, cpu_datasel, BOCI, cpu_search, invalidate_from_other_cpu and cpu_dmem_permission to the cores.

Parameters:
ADDR_W, 13, word address width (BICO/BOCI)
DATA_W, 16, word width on the snoop data path
MEM_TIMEOUT, 64, max cycles waiting on u_rdy before error flag

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
read_miss  input  [1:0]  per-core read-miss pulse (index = core)
write_miss  input  [1:0]  per-core write-miss pulse
invalidate  input  [1:0]  per-core upgrade (S->M) invalidate pulse
BICO0, BICO1  input  [12:0]  request address from core 0 / core 1
cpu_search_found  input  [1:0]  peer cache holds snooped line valid
send_other_proc_data0, send_other_proc_data1  input  [15:0]  snooped word from core 0 / 1
u_rdy  input  1  unified DMEM ready
grant  output  [1:0]  one-cycle completion strobe to owner
cpu_datasel0, cpu_datasel1  output  [1:0]  fill source: 00 DMEM, 01 other proc
BOCI0, BOCI1  output  [12:0]  snoop address driven into core 0 / 1
cpu_search  output  [1:0]  snoop lookup enable to each core
other_proc_data  output  [15:0]  registered snooped word to owner
invalidate_from_other_cpu  output  [1:0]  invalidate strobe to each core
cpu_dmem_permission  output  [1:0]  DMEM access permission per core
mem_timeout_err  output  1  sticky: DMEM wait exceeded MEM_TIMEOUT

Behaviour:
- Reset: all outputs 0; datasel outputs 00; state IDLE; pending cleared; last_served=1, so core 0 wins the first tie.
- Pending latch per core: type and address are captured on any request pulse. pending[i] stays set until that core's grant cycle. A new pulse in the same cycle as grant[i] re-sets pending (set wins). A second pulse while already pending overwrites type/address.
- Type priority within one core in a single cycle: write_miss > read_miss > invalidate.
- States:
  - IDLE: if any pending, owner = round-robin (prefer core != last_served). Latch addr/type. Go to INVAL for invalidate, else SNOOP. One cycle of arbitration latency.
- SNOOP (1 cycle): cpu_search[peer]=1; BOCI[peer]=latched addr. cpu_search_found[peer] is sampled at the end of this cycle.
  - Found: register send_other_proc_data[peer] into other_proc_data; datasel_owner=01. For write_miss, also pulse invalidate_from_other_cpu[peer] in the next cycle. Go to RESP.
  - Not found: go to MEM.
- MEM: cpu_dmem_permission[owner]=1, held until u_rdy=1; then datasel_owner=00 and go to RESP. A wait counter increments each cycle. On reaching MEM_TIMEOUT, set mem_timeout_err and still go to RESP; the controller never hangs.
- RESP (1 cycle): grant[owner]=1; cpu_datasel_owner held valid; other_proc_data stable; last_served=owner; go to IDLE.
- INVAL (1 cycle): invalidate_from_other_cpu[peer]=1; BOCI[peer]=addr; grant[owner]=1; last_served=owner; go to IDLE.
- Latency without contention:
  - Peer hit: IDLE→SNOOP→RESP, grant in the 3rd cycle after the pulse.
  - DMEM: 3 + u_rdy wait cycles.
  - Invalidate: grant in the 2nd cycle after the pulse.
- Datasel outputs hold their last value between transactions; only the owner's is updated.
- BOCI outputs are 0 except in SNOOP/INVAL/RESP for the peer.
- The arbiter never drives cpu_search or dmem permission to both cores at once. Grant is strictly one-hot.
- Asynchronous reset mid-transaction aborts immediately to IDLE with pending cleared; no grant is issued.

Decomposition:
- Add to package common:
  - arb_state_t {IDLE, SNOOP, MEM, RESP, INVAL}
  - bus_req_t {REQ_READ, REQ_WRITE, REQ_INV}
  - SOURCE_DMEM=2'b00, SOURCE_OTHER_PROC=2'b01 (move the existing cache_controller localparams here)
- One sub-module: bus_req_latch, instantiated twice, one per core, holding pending/type/address with the set-wins-over-clear rule.

Test Plan:
1. Reset, then read_miss[0] pulse, BICO0=13'h0104, found[1]=1, send_other_proc_data1=16'hBEEF → SNOOP with BOCI1=13'h0104; grant=2'b01 two cycles later; cpu_datasel0=01; other_proc_data=16'hBEEF.
2. write_miss[1], BICO1=13'h0020, found[0]=0, u_rdy low 5 cycles → cpu_dmem_permission=2'b10 for 6 cycles; grant=2'b10 after u_rdy; cpu_datasel1=00; no invalidate.
3. invalidate[0] with BICO0=13'h1FFF → invalidate_from_other_cpu=2'b10 and BOCI1=13'h1FFF in INVAL; grant=2'b01 in the same cycle.
4. read_miss on both cores in the same cycle → core 0 granted first; core 1 served next. Repeat the collision: core 1 is granted first.
5. write_miss[0] with peer found → grant[0] plus invalidate_from_other_cpu=2'b10 one cycle later; cpu_datasel0=01.
6. u_rdy held low → mem_timeout_err=1 after 64 cycles, grant still issued. Assert rst_n low mid-MEM → all outputs 0 and pending cleared.
